// File: rtl/fft_ctrl_pkg.sv
// Shared types and constants for the FFT stage-0/1 handoff control.
// State encodings, output-select codes and lane count.
package fft_ctrl_pkg;
   localparam int LANES = 16;
   localparam logic MUX_ADD = 1'b0;
   localparam logic MUX_SUB = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      CALC
   } in_state_t;

   typedef enum logic {
      O_IDLE,
      DRAIN
   } out_state_t;
endpackage

// File: rtl/fft_beat_cnt.sv
// Wrapping beat counter with clear and enable; clear+enable loads one.
// Width must match a power-of-two period so terminal count is all ones.
module fft_beat_cnt #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o,
   output logic         tc_o
);
   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) cnt_d = '0;
      if (en_i)  cnt_d = cnt_d + W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
   assign tc_o  = &cnt_q;
endmodule

// File: rtl/fft_bfly01_ctrl.sv
// Stage-0 to stage-1 handoff sequencer: FILL, CALC, then DRAIN of sub results.
// Define FFT_BFLY01_STATUS_EN to add frame_cnt / abort_cnt status outputs.
module fft_bfly01_ctrl
   import fft_ctrl_pkg::*;
#(
   parameter  int BLK_CYCLES = 16,
   localparam int CNT_W      = $clog2(BLK_CYCLES)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din_valid,
   input  logic             din_sop,
   output logic             buf_we,
   output logic [CNT_W-1:0] buf_addr,
   output logic             bfly_en,
   output logic             hold_we,
   output logic [CNT_W-1:0] hold_addr,
   output logic             mux_sel,
   output logic             dout_valid,
   output logic             dout_sop,
   output logic             dout_eop,
   output logic             busy,
   output logic             err_sync
`ifdef FFT_BFLY01_STATUS_EN
   ,
   output logic [15:0]      frame_cnt,
   output logic [7:0]       abort_cnt
`endif
);
   in_state_t  in_state_q, in_state_d;
   out_state_t out_state_q, out_state_d;

   logic             mux_sel_q, dout_valid_q, dout_sop_q;
   logic             dout_eop_q, busy_q, err_sync_q;
   logic [CNT_W-1:0] in_cnt, drain_cnt;
   logic             in_tc, drain_tc;

   logic v, sop;
   logic take_first, abort, bad_beat;
   logic fill_beat, calc_beat;
   logic drain_act, drain_start;

   assign v   = din_valid & ~rst;
   assign sop = v & din_sop;

   assign take_first = sop & (in_state_q == IDLE);
   assign abort      = sop & (in_state_q != IDLE);
   assign bad_beat   = v & ~din_sop & (in_state_q == IDLE);
   assign fill_beat  = v & ~din_sop & (in_state_q == FILL);
   assign calc_beat  = v & ~din_sop & (in_state_q == CALC);

   // A mid-frame sop kills any drain still in flight
   assign drain_act   = (out_state_q == DRAIN) & ~abort & ~rst;
   assign drain_start = calc_beat & in_tc;

   fft_beat_cnt #(.W(CNT_W)) u_in_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (abort),
      .en_i  (take_first | abort | fill_beat | calc_beat),
      .cnt_o (in_cnt),
      .tc_o  (in_tc)
   );

   fft_beat_cnt #(.W(CNT_W)) u_drain_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (abort),
      .en_i  (drain_act),
      .cnt_o (drain_cnt),
      .tc_o  (drain_tc)
   );

   assign buf_we    = take_first | abort | fill_beat;
   assign buf_addr  = (fill_beat | calc_beat) ? in_cnt : '0;
   assign bfly_en   = calc_beat;
   assign hold_we   = calc_beat;
   assign hold_addr = calc_beat ? in_cnt :
                      drain_act ? drain_cnt : '0;

   always_comb begin
      in_state_d = in_state_q;
      case (in_state_q)
         IDLE: if (take_first) in_state_d = FILL;
         FILL: begin
            if (abort)                   in_state_d = FILL;
            else if (fill_beat && in_tc) in_state_d = CALC;
         end
         CALC: begin
            if (abort)                   in_state_d = FILL;
            else if (calc_beat && in_tc) in_state_d = IDLE;
         end
         default: in_state_d = IDLE;
      endcase
      out_state_d = out_state_q;
      if (abort)                      out_state_d = O_IDLE;
      else if (drain_start)           out_state_d = DRAIN;
      else if (drain_act && drain_tc) out_state_d = O_IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         in_state_q   <= IDLE;
         out_state_q  <= O_IDLE;
         mux_sel_q    <= MUX_ADD;
         dout_valid_q <= 1'b0;
         dout_sop_q   <= 1'b0;
         dout_eop_q   <= 1'b0;
         busy_q       <= 1'b0;
         err_sync_q   <= 1'b0;
      end else begin
         in_state_q   <= in_state_d;
         out_state_q  <= out_state_d;
         dout_valid_q <= calc_beat | drain_act;
         dout_sop_q   <= calc_beat & (in_cnt == '0);
         dout_eop_q   <= drain_act & drain_tc;
         if (calc_beat)      mux_sel_q <= MUX_ADD;
         else if (drain_act) mux_sel_q <= MUX_SUB;
         busy_q     <= (in_state_d != IDLE) | (out_state_d != O_IDLE);
         err_sync_q <= err_sync_q | bad_beat | abort;
      end
   end

   assign mux_sel    = mux_sel_q;
   assign dout_valid = dout_valid_q;
   assign dout_sop   = dout_sop_q;
   assign dout_eop   = dout_eop_q;
   assign busy       = busy_q;
   assign err_sync   = err_sync_q;

`ifdef FFT_BFLY01_STATUS_EN
   logic [15:0] frame_cnt_q;
   logic [7:0]  abort_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt_q <= '0;
         abort_cnt_q <= '0;
      end else begin
         if (drain_act && drain_tc)
            frame_cnt_q <= frame_cnt_q + 16'd1;
         if (abort && abort_cnt_q != 8'hFF)
            abort_cnt_q <= abort_cnt_q + 8'd1;
      end
   end

   assign frame_cnt = frame_cnt_q;
   assign abort_cnt = abort_cnt_q;
`endif
endmodule

// File: doc/fft_bfly01_ctrl.md
Name: fft_bfly01_ctrl

Overview:
Sequencer for the stage-0 to stage-1 handoff of the 16-lane parallel FFT. It drives the stage-0 delay buffer, enables the butterfly, controls the sub-result hold bank, and drives the add/sub output-select line that picks which 16-lane result set feeds stage 1. It tracks a 2*BLK_CYCLES-beat input frame: FILL, CALC, then DRAIN.

Parameters:
BLK_CYCLES, 16, beats per half-frame (power of two, >=2)
CNT_W, $clog2(BLK_CYCLES), beat counter / address width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
din_valid  in  1  16-lane input beat present this cycle
din_sop  in  1  first beat of a frame; qualified by din_valid
buf_we  out  1  write current beat into delay buffer (comb)
buf_addr  out  CNT_W  delay buffer write/read address (comb)
bfly_en  out  1  butterfly consumes buffer[buf_addr] plus current beat (comb)
hold_we  out  1  write butterfly sub outputs into hold bank (comb, equals bfly_en)
hold_addr  out  CNT_W  hold bank address, write in CALC and read in DRAIN (comb)
mux_sel  out  1  0 = add results, 1 = sub results (registered)
dout_valid  out  1  stage-1 input valid (registered)
dout_sop  out  1  first output beat of frame (registered)
dout_eop  out  1  last output beat of frame (registered)
busy  out  1  any phase active (registered)
err_sync  out  1  sticky mis-framing flag (registered)

Behaviour:
- Reset (clk edge with rst=1): in_state=IDLE, out_state=O_IDLE, all counters 0, and mux_sel, dout_valid, dout_sop, dout_eop, busy, err_sync all 0. Comb outputs are 0 while rst=1.
- The input FSM (IDLE, FILL, CALC) counts only valid beats. in_cnt advances on din_valid and holds when din_valid=0, so gaps are legal.
- IDLE: din_valid&din_sop moves to FILL with in_cnt=1. That beat gives buf_we=1, buf_addr=0. din_valid without sop is dropped and err_sync is set.
- FILL: each valid beat gives buf_we=1, buf_addr=in_cnt. After beat BLK_CYCLES-1 the FSM moves to CALC with in_cnt=0.
- CALC: each valid beat gives bfly_en=1, hold_we=1, buf_addr=hold_addr=in_cnt. After beat BLK_CYCLES-1 the FSM returns to IDLE and out FSM DRAIN is triggered. A sop on beat 0 of the next frame in the following cycle is accepted with no bubble.
- Output side is registered, one cycle after the event:
  - Each CALC valid beat k gives dout_valid=1, mux_sel=0 next cycle; dout_sop=1 for k=0.
  - DRAIN runs BLK_CYCLES consecutive cycles with no gaps. Cycle j issues hold_addr=j (read). The next cycle gives dout_valid=1, mux_sel=1, and dout_eop on j=BLK_CYCLES-1.
- hold_addr mux: CALC write has priority. DRAIN cannot collide with the next CALC because the next FILL needs >=BLK_CYCLES cycles.
- mux_sel holds its last value when dout_valid=0.
- busy = in_state!=IDLE or out_state!=O_IDLE.
- din_sop on a valid beat outside IDLE-entry (mid-FILL/CALC): err_sync is set. The current frame is aborted and DRAIN is cancelled (dout_valid drops next cycle). The beat is taken as FILL beat 0.
- din_sop during DRAIN only is legal; DRAIN continues.
- err_sync clears only on rst.
- rst mid-frame: everything returns to reset values on the next edge, with no partial DRAIN.

Optional Feature:
- Macro FFT_BFLY01_STATUS_EN.
- Defined: adds output frame_cnt [15:0], incremented on each dout_eop and wrapping at 0xFFFF to 0, reset to 0. Also adds abort_cnt [7:0], incremented per mid-frame abort and saturating at 255.
- Undefined: neither port nor logic exists. All other behaviour is identical.

Decomposition:
- Package fft_ctrl_pkg:
  - in_state_t {IDLE, FILL, CALC}
  - out_state_t {O_IDLE, DRAIN}
  - localparam MUX_ADD=1'b0, MUX_SUB=1'b1
  - LANES=16
- One sub-module, fft_beat_cnt: enable/clear/terminal-count counter, instantiated for in_cnt and drain_cnt.

Test Plan:
- Continuous frame, BLK_CYCLES=16: sop at cycle 0 then 31 valid beats.
  - buf_we cycles 0-15, bfly_en cycles 16-31.
  - dout_valid cycles 17-48: mux_sel=0 for 17-32, 1 for 33-48.
  - dout_sop at 17, dout_eop at 48.
- Gapped input: din_valid toggling 1/0 -> buf_addr/hold_addr advance only on valid beats, 32 output beats total, 16 sub beats contiguous after the last CALC beat.
- Back-to-back frames: second sop at cycle 32 -> buf_we overlaps DRAIN cycles 32-47, no err_sync, mux_sel=0 again from cycle 49.
- Stray sop at FILL beat 5 -> err_sync=1 next cycle, buf_addr restarts at 0, following 31 beats complete normally.
- rst asserted at CALC beat 8 -> next cycle all outputs 0, busy=0. A new sop frame after reset completes correctly.
- With FFT_BFLY01_STATUS_EN: 3 full frames plus 1 aborted -> frame_cnt=3, abort_cnt=1.
